// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port of the multicycle core between the
// instruction-fetch path and the load/store data path. Only one transaction is
// outstanding at a time, and the memory has a fixed latency. When both paths
// request in the same idle cycle, the grant alternates (round-robin).
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   i_req/i_addr      fetch request (read only)
//   i_ready           fetch accepted this cycle when i_req & i_ready
//   i_valid/i_rdata   one-cycle fetch response; i_rdata holds between pulses
//   d_req/d_we/d_addr/d_wdata  load (d_we=0) or store (d_we=1) request
//   d_ready           data request accepted this cycle when d_req & d_ready
//   d_valid/d_rdata   one-cycle load data / store ack (d_rdata=0 for stores)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  fixed-latency memory port
//   busy              high whenever the FSM is not IDLE
//   state_dbg         current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: a requester holds req (with its address/data) until it sees
// ready high in the same cycle; that cycle is the accept. Dropping req before
// the accept cancels the request with no side effects. The response is a
// single valid pulse MEM_LATENCY+1 cycles after the accept, with no back-pressure.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              owner_d;    // 1 = current transaction belongs to data path
  logic              last_d;     // 1 = last grant went to data path
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_i;
  logic              grant_d;

  // Ready is gated by reset so requests held through reset are not accepted
  // until the first cycle after it deasserts. On a tie the requester that
  // did not win last time is granted.
  always_comb begin
    grant_i = (state == IDLE) && !reset && i_req && (!d_req || last_d);
    grant_d = (state == IDLE) && !reset && d_req && (!i_req || !last_d);
  end

  assign i_ready   = grant_i;
  assign d_ready   = grant_d;
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_valid   = (state == DONE) && !owner_d;
  assign d_valid   = (state == DONE) && owner_d;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      last_d    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            addr_q  <= i_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            cnt     <= CNT_INIT;
            state   <= ACCESS;
          end else if (grant_d) begin
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            owner_d <= 1'b1;
            last_d  <= 1'b1;
            cnt     <= CNT_INIT;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // cnt == 0 marks the last access cycle: read data is stable now.
          if (cnt == 4'd0) begin
            if (owner_d) begin
              d_rdata_q <= we_q ? '0 : mem_rdata;
            end else begin
              i_rdata_q <= mem_rdata;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. The main instance runs with MEM_LATENCY=4, and a
// second instance runs with MEM_LATENCY=1. The model predicts readiness,
// memory-port activity and response timing from cycle arithmetic. It uses a
// shadow memory for the expected data.
module tb_mem_port_arbiter;
  localparam int L = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT signals ----------------
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_ready, i_valid, d_ready, d_valid, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;

  // ---------------- latency-1 DUT signals ----------------
  logic        i_req_1 = 0, d_req_1 = 0, d_we_1 = 0;
  logic [31:0] i_addr_1 = 0, d_addr_1 = 0, d_wdata_1 = 0;
  logic        i_ready_1, i_valid_1, d_ready_1, d_valid_1, mem_en_1, mem_we_1, busy_1;
  logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [1:0]  state_dbg_1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut_1 (
    .clk(clk), .reset(reset),
    .i_req(i_req_1), .i_addr(i_addr_1), .i_ready(i_ready_1), .i_valid(i_valid_1), .i_rdata(i_rdata_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_ready(d_ready_1), .d_valid(d_valid_1), .d_rdata(d_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .busy(busy_1), .state_dbg(state_dbg_1)
  );

  // ---------------- memory + shadow copy ----------------
  logic [31:0] mem [0:255];
  logic [31:0] sh  [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i * 32'h0101_0101) ^ 32'h1234_5678;
      sh[i]  = (i * 32'h0101_0101) ^ 32'h1234_5678;
    end
    mem[4] = 32'h0050_0093;
    sh[4]  = 32'h0050_0093;
  end
  assign mem_rdata   = mem[mem_addr[9:2]];
  assign mem_rdata_1 = mem[mem_addr_1[9:2]];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  bit run = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction accepted in cycle c occupies the port in
  // cycles c+1..c+L and answers in cycle c+L+1; the FSM is idle otherwise.
  bit          txn = 0;
  int          acc_cyc = 0;
  bit          t_we = 0;
  logic [31:0] t_addr = 0, t_wdata = 0;
  bit          last_d = 1;

  always @(negedge clk) begin
    bit acc, dn, idle, ei, ed;
    exp_t e;
    if (run) begin
      if (txn && cyc > acc_cyc + L + 1) txn = 0;
      acc  = txn && cyc > acc_cyc && cyc <= acc_cyc + L;
      dn   = txn && cyc == acc_cyc + L + 1;
      idle = !acc && !dn;
      ei   = !reset && idle && i_req && (!d_req || last_d);
      ed   = !reset && idle && d_req && (!i_req || !last_d);
      check("i_ready", i_ready, ei);
      check("d_ready", d_ready, ed);
      check("busy", busy, !idle);
      check("mem_en", mem_en, acc);
      check("mem_we", mem_we, acc && t_we);
      if (acc) check("mem_addr", mem_addr, t_addr);
      if (acc && t_we) check("mem_wdata", mem_wdata, t_wdata);
      if (reset) begin
        txn = 0;
        last_d = 1;
        exp_q.delete();
      end else if (ei || ed) begin
        txn     = 1;
        acc_cyc = cyc;
        t_we    = ed && d_we;
        t_addr  = ed ? d_addr : i_addr;
        t_wdata = d_wdata;
        last_d  = ed;
        e.cyc   = 32'(cyc + L + 1);
        e.is_d  = ed;
        if (t_we) begin
          e.data = 32'h0;
          sh[t_addr[9:2]] = d_wdata;
        end else begin
          e.data = sh[t_addr[9:2]];
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pops an expectation whenever a response pulse appears.
  always @(negedge clk) begin
    exp_t m;
    if (run) begin
      check("valid_exclusive", i_valid && d_valid, 0);
      if (i_valid || d_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got i_valid=%0b d_valid=%0b expected none (cycle %0d)",
                   i_valid, d_valid, cyc);
        end else begin
          m = exp_q.pop_front();
          check("valid_owner", d_valid, m.is_d);
          check("valid_cycle", cyc, m.cyc);
          check("rdata", d_valid ? d_rdata : i_rdata, m.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        m = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_valid: got none expected pulse at cycle %0d (now %0d)", m.cyc, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit acc;
    acc = 0;
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1; i_addr = addr;
    end
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = is_d ? d_ready : i_ready;
      tick();
    end
    if (is_d) d_req = 0; else i_req = 0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 40 cycles");
    end
  endtask

  task automatic wait_valid(input bit is_d, output logic [31:0] data);
    bit got;
    got = 0;
    data = 32'h0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (is_d ? d_valid : i_valid) begin
        got = 1;
        data = is_d ? d_rdata : i_rdata;
      end
    end
    tick();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got no valid expected valid within 40 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    bit grants[$];

    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_mem_en", mem_en, 0);
    check("reset_valid", i_valid | d_valid, 0);
    check("reset_rdata", i_rdata | d_rdata, 0);
    run = 1;
    tick();
    reset = 1'b0;

    // 1: single fetch
    do_req(0, 0, 32'h10, 32'h0);
    wait_valid(0, rd);
    check("t1_fetch_data", rd, 32'h0050_0093);
    @(negedge clk);
    check("t1_idle_after", busy, 0);
    tick();

    // 2: store then load back
    do_req(1, 1, 32'h100, 32'hDEAD_BEEF);
    wait_valid(1, rd);
    check("t2_store_ack", rd, 32'h0);
    do_req(1, 0, 32'h100, 32'h0);
    wait_valid(1, rd);
    check("t2_load_back", rd, 32'hDEAD_BEEF);

    // 3: contention after reset, grant order fetch, data, fetch
    do_reset(2);
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int n = 0; n < 3 * (L + 2) + 2; n++) begin
      @(negedge clk);
      if (i_ready) grants.push_back(1'b0);
      if (d_ready) grants.push_back(1'b1);
      tick();
    end
    i_req = 0; d_req = 0;
    check("t3_grant_count_ge3", grants.size() >= 3, 1);
    if (grants.size() >= 3) begin
      check("t3_grant0_fetch", grants[0], 0);
      check("t3_grant1_data", grants[1], 1);
      check("t3_grant2_fetch", grants[2], 0);
    end
    repeat (L + 3) tick();

    // 4: one-cycle data pulse while a fetch is in ACCESS is cancelled
    do_req(0, 0, 32'h14, 32'h0);
    d_req = 1; d_we = 1; d_addr = 32'h18; d_wdata = 32'h5555_AAAA;
    tick();
    d_req = 0;
    wait_valid(0, rd);
    repeat (L + 3) tick();

    // 5: reset in the second ACCESS cycle of a load, both reqs held
    do_req(1, 0, 32'h20, 32'h0);
    tick();
    reset = 1; i_req = 1; i_addr = 32'h24; d_req = 1; d_addr = 32'h28; d_we = 0;
    tick();
    reset = 0;
    @(negedge clk);
    check("t5_mem_en", mem_en, 0);
    check("t5_busy", busy, 0);
    check("t5_d_valid", d_valid, 0);
    check("t5_first_grant_fetch", i_ready, 1);
    tick();
    i_req = 0; d_req = 0;
    repeat (L + 3) tick();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      i_req   = ($urandom_range(0, 2) != 0);
      i_addr  = 32'($urandom_range(0, 255)) << 2;
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      d_addr  = 32'($urandom_range(0, 255)) << 2;
      d_wdata = $urandom;
      tick();
    end
    i_req = 0; d_req = 0;
    repeat (L + 8) tick();
    check("queue_drained", exp_q.size(), 0);

    // 6: latency-1 instance, load from 0x8
    d_req_1 = 1; d_we_1 = 0; d_addr_1 = 32'h8;
    @(negedge clk);
    check("t6_d_ready", d_ready_1, 1);
    check("t6_i_ready", i_ready_1, 0);
    tick();
    d_req_1 = 0;
    @(negedge clk);
    check("t6_mem_en", mem_en_1, 1);
    check("t6_mem_addr", mem_addr_1, 32'h8);
    check("t6_mem_we", mem_we_1, 0);
    check("t6_early_valid", d_valid_1, 0);
    check("t6_state_access", state_dbg_1, 1);
    @(negedge clk);
    check("t6_d_valid", d_valid_1, 1);
    check("t6_d_rdata", d_rdata_1, sh[2]);
    check("t6_mem_en_off", mem_en_1, 0);
    check("t6_i_valid", i_valid_1, 0);
    @(negedge clk);
    check("t6_idle", busy_1, 0);
    check("t6_pulse_end", d_valid_1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL global_timeout: got still running expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified memory port of the multicycle core between two requesters: the instruction-fetch path and the load/store data path.
- Sits between the control unit/datapath and the memory model, replacing the direct i_or_d memory mux.
- Handles one outstanding transaction at a time over a fixed-latency memory.
- Applies round-robin arbitration when both requesters contend in the same cycle.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width
MEM_LATENCY  4  memory cycles per access, from grant to read data stable; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  instruction fetch request (read only)
i_addr  in  ADDR_W  fetch address
i_ready  out  1  fetch request accepted this cycle when i_req & i_ready
i_valid  out  1  one-cycle pulse: fetch data on i_rdata
i_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  data request accepted this cycle when d_req & d_ready
d_valid  out  1  one-cycle pulse: load data or store acknowledge
d_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, stable at end of the last access cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Synchronous, active-high reset. All outputs go to 0. State = IDLE, counter = 0, last_grant = DATA, so the first tie goes to fetch.
- States: IDLE, ACCESS, DONE. Registered state; all outputs derived from registered state.
- IDLE:
  - ready is combinational.
  - Only i_req high: i_ready = 1.
  - Only d_req high: d_ready = 1.
  - Both high: grant the requester that is not last_grant; the other ready stays 0.
  - At most one of i_ready and d_ready is high in any cycle.
  - On accept: latch addr, we (fetch forces we = 0) and wdata; record owner; update last_grant; load counter = MEM_LATENCY-1; go to ACCESS.
- Outside IDLE: i_ready = d_ready = 0.
- Requests are level-sensitive. An unaccepted request stays pending only while its req is held. Dropping req before accept cancels it with no side effects.
- ACCESS:
  - mem_en = 1; mem_addr and mem_wdata come from the latches.
  - mem_we = latched we, held for every ACCESS cycle; memory commits the write at the last ACCESS edge.
  - Counter decrements each cycle.
  - When counter = 0: capture mem_rdata into the response register (0 if write) and go to DONE.
- DONE:
  - The owner's valid = 1 for exactly one cycle, with rdata from the response register.
  - The other valid = 0; mem_en = 0.
  - Next state is IDLE.
- Latency: accept at edge T → ACCESS for MEM_LATENCY cycles → valid high in cycle T+MEM_LATENCY+1 → IDLE. There is no back-to-back accept in DONE.
- i_rdata and d_rdata hold their last response value between pulses.
- MEM_LATENCY = 1: a single ACCESS cycle.
- Reset mid-ACCESS or mid-DONE: transaction abandoned, no valid pulse, state = IDLE next cycle, last_grant = DATA.
- A write already partially driven may or may not commit to memory; software must not depend on either outcome.
- Requests asserted during reset are ignored. They are accepted in the first cycle after reset deasserts, if still held.
- Address and data are passed unmodified; no alignment checks.

Test Plan:
1. Reset, then i_req = 1, i_addr = 0x0000_0010, memory word = 0x0050_0093 → i_ready = 1 in cycle 0. mem_en = 1 with mem_addr = 0x10 in cycles 1–4. i_valid = 1 with i_rdata = 0x0050_0093 in cycle 5 only. busy = 0 in cycle 6.
2. d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF → mem_we = 1 for 4 cycles, then d_valid pulse with d_rdata = 0. A later load from 0x100 returns 0xDEAD_BEEF.
3. Contention after reset, i_req and d_req both held:
   - Grants go fetch, then data, then fetch.
   - i_ready and d_ready are never high together.
   - Each valid pulse goes only to its owner.
4. Cancel: d_req pulses for 1 cycle while a fetch is in ACCESS → d_ready stays 0, no data transaction, no d_valid, state returns to IDLE.
5. Assert reset in the second ACCESS cycle of a load → no d_valid, all outputs 0. With i_req held high through reset, the next cycle after reset is the first grant, to fetch (last_grant = DATA).
6. MEM_LATENCY = 1 build: load from 0x8 → mem_en for 1 cycle, d_valid 2 cycles after accept, correct data.
